// File: rtl/override_pkg.sv
// Shared state encoding for the override register: bit 1 = force active,
// bit 0 = hold active, so FORCED_HELD is simply both flags set.
package override_pkg;

  typedef enum logic [1:0] {
    NORMAL      = 2'd0,
    HELD        = 2'd1,
    FORCED      = 2'd2,
    FORCED_HELD = 2'd3
  } ovr_state_t;

  localparam int HOLD_BIT  = 0;
  localparam int FORCE_BIT = 1;

  function automatic ovr_state_t make_state(input logic forced, input logic held);
    return ovr_state_t'({forced, held});
  endfunction

endpackage

// File: rtl/override_timer.sv
// Force-duration counter: loads a cycle count, counts down while a force is
// active, and flags the cycle in which the force must release (0 = never).
module override_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             clr_i,
  input  logic             run_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  // A reload in the same cycle restarts the duration, so it masks expiry.
  assign expire_o = run_i & ~load_i & (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (clr_i || expire_o) begin
      cnt_q <= '0;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/override_reg.sv
// Register with a hold override and an optional timed force override.
// The force path is built only when OVERRIDE_REG_FORCE_EN is defined.
module override_reg
  import override_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             hold_set,
  input  logic             hold_clr,
  input  logic [WIDTH-1:0] hold_data,
  input  logic             force_set,
  input  logic             force_clr,
  input  logic [WIDTH-1:0] force_data,
  input  logic [CNT_W-1:0] force_cycles,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       state,
  output logic             force_done
);

  ovr_state_t       state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] hold_val_q, hold_val_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             held, forced, held_d, forced_d;
  logic             force_set_eff, force_rel;
  logic [WIDTH-1:0] force_val_cur, force_val_nx;

  assign held   = state_q[HOLD_BIT];
  assign forced = state_q[FORCE_BIT];

`ifdef OVERRIDE_REG_FORCE_EN
  logic [WIDTH-1:0] force_val_q;
  logic             force_done_q;
  logic             expire;

  assign force_set_eff = force_set & ~force_clr;
  assign force_rel     = forced & (force_clr | expire);
  assign force_val_cur = force_val_q;
  assign force_val_nx  = force_set_eff ? force_data : force_val_q;
  assign force_done    = force_done_q;

  override_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (force_set_eff),
    .load_val_i (force_cycles),
    .clr_i      (force_rel),
    .run_i      (forced),
    .expire_o   (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      force_val_q  <= '0;
      force_done_q <= 1'b0;
    end else begin
      force_val_q  <= force_val_nx;
      force_done_q <= expire;
    end
  end
`else
  logic unused_force;

  assign unused_force  = ^{force_set, force_clr, force_data, force_cycles};
  assign force_set_eff = 1'b0;
  assign force_rel     = 1'b0;
  assign force_val_cur = '0;
  assign force_val_nx  = '0;
  assign force_done    = 1'b0;
`endif

  always_comb begin
    held_d     = held;
    hold_val_d = hold_val_q;
    base_d     = base_q;
    // Clear beats set; while forced only the underlying hold is touched.
    if (hold_clr) begin
      held_d = 1'b0;
    end else if (hold_set) begin
      held_d     = 1'b1;
      hold_val_d = hold_data;
    end
    forced_d = forced ? ~force_rel : force_set_eff;
    if (!forced && !held && wr_en) begin
      base_d = wr_data;
    end else if (!forced && held && hold_clr) begin
      base_d = hold_val_q;
    end
    if (force_rel && !held_d) begin
      base_d = force_val_cur;
    end
    state_d = make_state(forced_d, held_d);
    q_d     = forced_d ? force_val_nx : (held_d ? hold_val_d : base_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      base_q     <= '0;
      hold_val_q <= '0;
      q_q        <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      hold_val_q <= hold_val_d;
      q_q        <= q_d;
    end
  end

  assign q     = q_q;
  assign state = state_q;

endmodule
